ram_wr: RTL and testbench
=========================

Name: ram_wr

Overview:
- Capture-side writer for the waveform display RAM in the signal generator top.
- Takes a 12-bit sample stream from the DDS/ADC path, decimates it, and waits for a rising-edge level trigger.
- Then writes DEPTH consecutive samples to RAM addresses 0..DEPTH-1.
- Holds the frame until the display side releases it, so the display reader always scans a stable, trigger-aligned trace.

Parameters:
- DEPTH, 640, samples per frame; one sample per display x position; must be ≤ 1024.
- TIMEOUT, 4096, accepted samples without a trigger before a forced (auto) trigger.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  single-cycle pulse; arms a capture from IDLE
- continuous  input  1  1 = re-arm automatically after each release
- hold_release  input  1  single-cycle pulse from display timing (end of frame); frees a held frame
- trig_en  input  1  1 = level trigger; 0 = trigger on first accepted sample
- trig_level  input  12  trigger threshold, unsigned
- decim  input  8  keep one sample in every decim+1 valid samples
- sample_valid  input  1  sample_data qualifier
- sample_data  input  12  unsigned sample
- ram_wr_en  output  1  RAM write strobe
- ram_wr_addr  output  10  RAM write address
- ram_wr_data  output  12  RAM write data
- busy  output  1  high in WAIT_TRIG or CAPTURE
- frame_ready  output  1  high in HOLD; RAM contents complete and stable
- trig_timeout  output  1  last frame was auto-triggered; sticky until the next trigger event

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0.
  - busy=0, frame_ready=0, trig_timeout=0.
  - Decimation counter, sample index, timeout counter and prev-valid flag all cleared.
  - Applies mid-capture as well: no further writes after the reset edge.
- Decimation:
  - dec_cnt counts 0..decim on each sample_valid and wraps to 0.
  - A sample is "accepted" when sample_valid=1 and dec_cnt==0.
  - decim=0 accepts every valid sample.
  - dec_cnt is cleared on entry to WAIT_TRIG.
- States:
  - IDLE: start=1 -> WAIT_TRIG.
  - WAIT_TRIG:
    - prev holds the last accepted sample; prev_valid is cleared on entry.
    - Trigger condition on an accepted sample s: trig_en=0; or prev_valid and prev<trig_level and s>=trig_level (unsigned compare).
    - The timeout counter increments per accepted non-triggering sample. An accepted sample arriving when count==TIMEOUT-1 forces the trigger and sets trig_timeout=1.
    - A level trigger clears trig_timeout.
    - The triggering sample itself is written to address 0 -> CAPTURE with index=1.
  - CAPTURE:
    - Each accepted sample is written at address index, then index increments.
    - The write of address DEPTH-1 -> HOLD.
  - HOLD:
    - frame_ready=1; no writes; samples ignored.
    - hold_release=1 -> WAIT_TRIG if continuous=1, else IDLE.
    - frame_ready drops in the cycle after release.
- Write timing:
  - ram_wr_en pulses for 1 cycle, registered one cycle after the accepted sample's edge.
  - ram_wr_addr and ram_wr_data are valid in that same cycle.
  - ram_wr_en is never high for two writes to the same address within one frame.
- Ignored / non-interfering inputs:
  - start is ignored outside IDLE.
  - hold_release is ignored outside HOLD.
  - start and hold_release in the same cycle while in HOLD: hold_release wins, start is ignored.
  - The trig_level and decim values sampled at each accepted sample are used; changing them mid-frame is legal.
- Outputs:
  - busy = (state==WAIT_TRIG or CAPTURE), registered.
  - Exactly DEPTH writes per frame, addresses strictly 0,1,...,DEPTH-1.

Test Plan:
- Reset then start, trig_en=0, decim=0, DEPTH=8, samples 100..107 every cycle:
  - Expect writes addr0..7 with data 100..107 on consecutive cycles.
  - Then frame_ready=1, busy=0.
- Level trigger, trig_level=2048, ramp 2040,2044,2048,2052,..., decim=0:
  - addr0 = 2048 (first crossing sample); trig_timeout=0.
  - No trigger on a sample ≥2048 arriving as the first sample after arming.
- decim=2, trig_en=0, sample_valid every cycle, data = cycle count:
  - Written data are every 3rd sample (n, n+3, n+6, ...).
  - ram_wr_en asserts at most once per 3 cycles.
- Constant input 100, trig_en=1, trig_level=2048, TIMEOUT=16:
  - Forced trigger on the 16th accepted sample; addr0 = 100; trig_timeout=1.
- continuous=1:
  - After frame_ready, pulse hold_release -> frame_ready=0 the next cycle, busy=1, and a second frame is written from addr0.
  - With continuous=0 -> IDLE, no writes until start.
- rst=1 asserted during CAPTURE at addr 3:
  - No ram_wr_en after the reset edge; all outputs return to 0.
  - start pulses before and during HOLD are ignored (no extra writes).

Source files
------------

// File: rtl/ram_wr_if.sv
// ram_wr_if: sample stream in, RAM write bus out, for the display RAM writer.
//   sample_valid / sample_data : 12-bit unsigned sample stream from the DDS/ADC path
//   ram_wr_en / ram_wr_addr / ram_wr_data : single-cycle write strobe into the display RAM
// Modports:
//   master : system side (drives samples, observes the RAM bus)
//   slave  : ram_wr itself (consumes samples, drives the RAM bus)
interface ram_wr_if;
  logic        sample_valid;
  logic [11:0] sample_data;
  logic        ram_wr_en;
  logic [9:0]  ram_wr_addr;
  logic [11:0] ram_wr_data;

  modport master (output sample_valid, sample_data,
                  input  ram_wr_en, ram_wr_addr, ram_wr_data);
  modport slave  (input  sample_valid, sample_data,
                  output ram_wr_en, ram_wr_addr, ram_wr_data);
endinterface

// File: rtl/ram_wr.sv
// ram_wr: capture-side writer for the waveform display RAM.
// Decimates the sample stream, waits for a rising-edge level trigger (or a
// forced trigger after TIMEOUT accepted samples), writes DEPTH samples to
// addresses 0..DEPTH-1, then holds the frame until the display releases it.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : pulse, arms a capture from IDLE
//   continuous    : re-arm automatically after each release
//   hold_release  : pulse, frees a held frame
//   trig_en       : 1 = level trigger, 0 = trigger on first accepted sample
//   trig_level    : unsigned trigger threshold
//   decim         : keep one in every decim+1 valid samples
//   bus           : sample stream in, RAM write bus out (ram_wr_if.slave)
//   busy          : armed or capturing
//   frame_ready   : frame complete and stable in RAM
//   trig_timeout  : last frame was auto-triggered (sticky until next trigger)
module ram_wr #(
  parameter int DEPTH   = 640,
  parameter int TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         continuous,
  input  logic         hold_release,
  input  logic         trig_en,
  input  logic [11:0]  trig_level,
  input  logic [7:0]   decim,
  ram_wr_if.slave      bus,
  output logic         busy,
  output logic         frame_ready,
  output logic         trig_timeout
);

  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [9:0]      LAST_IDX = 10'(DEPTH - 1);
  localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAP, S_HOLD} state_t;

  state_t         state_q,      state_d;
  logic [7:0]     dec_cnt_q,    dec_cnt_d;
  logic [9:0]     idx_q,        idx_d;
  logic [TW-1:0]  to_cnt_q,     to_cnt_d;
  logic [11:0]    prev_q,       prev_d;
  logic           prev_valid_q, prev_valid_d;
  logic           trig_to_q,    trig_to_d;
  logic           wr_en_q,      wr_en_d;
  logic [9:0]     wr_addr_q,    wr_addr_d;
  logic [11:0]    wr_data_q,    wr_data_d;
  logic           busy_q,       busy_d;
  logic           frame_rdy_q,  frame_rdy_d;

  logic accept;
  logic level_hit;

  always_comb begin
    state_d      = state_q;
    dec_cnt_d    = dec_cnt_q;
    idx_d        = idx_q;
    to_cnt_d     = to_cnt_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    trig_to_d    = trig_to_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    // ">=" rather than "==" so a decim lowered mid-count still wraps promptly.
    if (bus.sample_valid)
      dec_cnt_d = (dec_cnt_q >= decim) ? 8'd0 : dec_cnt_q + 8'd1;

    accept    = bus.sample_valid && (dec_cnt_q == 8'd0);
    level_hit = prev_valid_q && (prev_q < trig_level) &&
                (bus.sample_data >= trig_level);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_WAIT;
          dec_cnt_d    = 8'd0;
          to_cnt_d     = '0;
          prev_valid_d = 1'b0;
        end
      end

      S_WAIT: begin
        if (accept) begin
          if (!trig_en || level_hit || to_cnt_q == TO_LAST) begin
            // Only a trigger that comes purely from the timeout marks the frame auto.
            trig_to_d = !(!trig_en || level_hit);
            wr_en_d   = 1'b1;
            wr_addr_d = 10'd0;
            wr_data_d = bus.sample_data;
            idx_d     = 10'd1;
            state_d   = (LAST_IDX == 10'd0) ? S_HOLD : S_CAP;
          end else begin
            to_cnt_d     = to_cnt_q + TW'(1);
            prev_d       = bus.sample_data;
            prev_valid_d = 1'b1;
          end
        end
      end

      S_CAP: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = bus.sample_data;
          if (idx_q == LAST_IDX) state_d = S_HOLD;
          else                   idx_d   = idx_q + 10'd1;
        end
      end

      S_HOLD: begin
        // start is deliberately not looked at here; release alone decides.
        if (hold_release) begin
          if (continuous) begin
            state_d      = S_WAIT;
            dec_cnt_d    = 8'd0;
            to_cnt_d     = '0;
            prev_valid_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d == S_WAIT) || (state_d == S_CAP);
    frame_rdy_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      dec_cnt_q    <= '0;
      idx_q        <= '0;
      to_cnt_q     <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      trig_to_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_rdy_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      dec_cnt_q    <= dec_cnt_d;
      idx_q        <= idx_d;
      to_cnt_q     <= to_cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      trig_to_q    <= trig_to_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      frame_rdy_q  <= frame_rdy_d;
    end
  end

  assign bus.ram_wr_en   = wr_en_q;
  assign bus.ram_wr_addr = wr_addr_q;
  assign bus.ram_wr_data = wr_data_q;
  assign busy            = busy_q;
  assign frame_ready     = frame_rdy_q;
  assign trig_timeout    = trig_to_q;

endmodule

// File: tb/tb_ram_wr.sv
// tb_ram_wr: randomized + directed stimulus for ram_wr with a behavioural
// reference model; expected writes and per-cycle status go into queues that
// a separate monitor drains after every clock edge.
module tb_ram_wr;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst, start, continuous, hold_release, trig_en;
  logic [11:0] trig_level;
  logic [7:0]  decim;
  logic        busy, frame_ready, trig_timeout;

  ram_wr_if bus();

  ram_wr #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .hold_release(hold_release), .trig_en(trig_en), .trig_level(trig_level),
    .decim(decim), .bus(bus.slave), .busy(busy), .frame_ready(frame_ready),
    .trig_timeout(trig_timeout)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { bit wen; bit busy; bit fr; bit tto; bit zero; } st_t;

  wr_t wq[$];
  st_t sq[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 armed, 2 capturing, 3 holding.
  int m_phase = 0, m_nvalid = 0, m_rejects = 0, m_wptr = 0, m_prev = 0;
  bit m_prev_ok = 0, m_tto = 0;

  task automatic arm();
    m_phase = 1; m_nvalid = 0; m_rejects = 0; m_prev_ok = 0;
  endtask

  // Evaluates the rules on the inputs presented before the coming clock edge.
  task automatic model_step();
    st_t s;
    bit  acc, lvl, fire;
    int  smp;
    s = '{default: 0};
    smp = int'(bus.sample_data);
    if (rst) begin
      m_phase = 0; m_tto = 0; s.zero = 1;
    end else begin
      acc = 0;
      if ((m_phase == 1 || m_phase == 2) && bus.sample_valid) begin
        acc = (m_nvalid % (int'(decim) + 1)) == 0;
        m_nvalid++;
      end
      case (m_phase)
        0: if (start) arm();
        1: if (acc) begin
          lvl  = m_prev_ok && m_prev < int'(trig_level) && smp >= int'(trig_level);
          fire = 1;
          if (!trig_en || lvl)               m_tto = 0;
          else if (m_rejects == TIMEOUT - 1) m_tto = 1;
          else begin
            fire = 0; m_rejects++; m_prev = smp; m_prev_ok = 1;
          end
          if (fire) begin
            wq.push_back('{addr: 0, data: smp}); s.wen = 1;
            m_wptr = 1; m_phase = (DEPTH == 1) ? 3 : 2;
          end
        end
        2: if (acc) begin
          wq.push_back('{addr: m_wptr, data: smp}); s.wen = 1;
          m_wptr++;
          if (m_wptr == DEPTH) m_phase = 3;
        end
        3: if (hold_release) begin
          if (continuous) arm(); else m_phase = 0;
        end
        default: m_phase = 0;
      endcase
    end
    s.busy = (m_phase == 1 || m_phase == 2);
    s.fr   = (m_phase == 3);
    s.tto  = m_tto;
    sq.push_back(s);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input int d);
    bus.sample_valid = v;
    bus.sample_data  = 12'(d);
  endtask

  // Monitor: one status entry per edge; one write entry per observed strobe.
  st_t ms;
  wr_t mw;
  always @(posedge clk) begin
    #1;
    if (sq.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL status_queue: got empty expected entry at %0t", $time);
    end else begin
      ms = sq.pop_front();
      chk("ram_wr_en",    int'(bus.ram_wr_en), int'(ms.wen));
      chk("busy",         int'(busy),          int'(ms.busy));
      chk("frame_ready",  int'(frame_ready),   int'(ms.fr));
      chk("trig_timeout", int'(trig_timeout),  int'(ms.tto));
      if (ms.zero) begin
        chk("rst_addr", int'(bus.ram_wr_addr), 0);
        chk("rst_data", int'(bus.ram_wr_data), 0);
      end
    end
    if (bus.ram_wr_en === 1'b1) begin
      if (wq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL extra_write: got addr %0d expected no write", bus.ram_wr_addr);
      end else begin
        mw = wq.pop_front();
        chk("ram_wr_addr", int'(bus.ram_wr_addr), mw.addr);
        chk("ram_wr_data", int'(bus.ram_wr_data), mw.data);
      end
    end
  end

  int cyc = 0;

  initial begin
    rst = 1; start = 0; continuous = 0; hold_release = 0; trig_en = 0;
    trig_level = 12'd0; decim = 8'd0; drive(0, 0);
    tick(); tick();

    // Free-running trigger, every sample accepted, 100..107.
    rst = 0; start = 1; tick(); start = 0;
    for (int i = 0; i < DEPTH; i++) begin drive(1, 100 + i); tick(); end
    // Held: samples and start pulses must not write.
    for (int i = 0; i < 4; i++) begin drive(1, 500 + i); start = (i == 1); tick(); end
    start = 0; hold_release = 1; tick(); hold_release = 0;
    for (int i = 0; i < 3; i++) begin drive(1, 7); tick(); end

    // Level trigger; an above-level first sample must not fire.
    trig_en = 1; trig_level = 12'd2048; drive(0, 0); start = 1; tick(); start = 0;
    drive(1, 2060); tick();
    for (int i = 0; i < DEPTH + 4; i++) begin drive(1, 2040 + 4 * i); tick(); end
    hold_release = 1; drive(0, 0); tick(); hold_release = 0;

    // Decimate by 3, data = cycle count, free-running trigger.
    trig_en = 0; decim = 8'd2; start = 1; tick(); start = 0;
    for (int i = 0; i < 3 * DEPTH + 4; i++) begin drive(1, cyc); cyc++; tick(); end
    hold_release = 1; drive(0, 0); tick(); hold_release = 0;

    // Constant below-level input forces timeout; continuous re-arm for a second frame.
    decim = 8'd0; trig_en = 1; trig_level = 12'd2048; continuous = 1;
    start = 1; tick(); start = 0;
    for (int i = 0; i < TIMEOUT + DEPTH + 3; i++) begin drive(1, 100); tick(); end
    hold_release = 1; tick(); hold_release = 0;
    for (int i = 0; i < TIMEOUT + DEPTH + 3; i++) begin drive(1, 100); tick(); end
    continuous = 0; hold_release = 1; tick(); hold_release = 0;
    for (int i = 0; i < 4; i++) begin drive(1, 100); tick(); end

    // Reset while capturing at address 3.
    trig_en = 0; start = 1; drive(0, 0); tick(); start = 0;
    for (int i = 0; i < 4; i++) begin drive(1, 300 + i); tick(); end
    rst = 1; drive(1, 304); tick(); rst = 0;
    for (int i = 0; i < 5; i++) begin drive(1, 305 + i); tick(); end

    // Randomized traffic; decim only changes while the model is idle.
    for (int blk = 0; blk < 6; blk++) begin
      continuous = 1'($urandom_range(0, 1));
      for (int i = 0; i < 600; i++) begin
        if (m_phase == 0) decim = 8'($urandom_range(0, 3));
        trig_en      = ($urandom_range(0, 3) != 0);
        trig_level   = 12'($urandom_range(0, 4095));
        start        = ($urandom_range(0, 19) == 0);
        hold_release = ($urandom_range(0, 9) == 0);
        rst          = ($urandom_range(0, 399) == 0);
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 4095));
        tick();
      end
      rst = 0; start = 0; hold_release = 0;
    end

    drive(0, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("write_queue_drained", wq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
